// File: rtl/disp_pkg.sv
// Shared constants, state type and helpers for the shared seven-segment display arbiter.
package disp_pkg;

    localparam int N_REQ   = 3;
    localparam int DATA_W  = 20;
    localparam int POINT_W = 6;
    localparam int DWELL_W = 26;

    // 100 ms and 1 s hold times at a 50 MHz clock
    localparam int DEF_DWELL_SHORT = 5_000_000;
    localparam int DEF_DWELL_LONG  = 50_000_000;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Converts a one-hot requester vector into its index; zero maps to requester 0
    function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] onehot);
        logic [1:0] idx;
        case (onehot)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/disp_share_arb_if.sv
// Request/grant/display bundle between the display requesters and the arbiter.
interface disp_share_arb_if;
    import disp_pkg::*;

    logic                             dwell_sel;
    logic [N_REQ-1:0]                 req;
    logic [N_REQ-1:0][DATA_W-1:0]     req_data;
    logic [N_REQ-1:0][POINT_W-1:0]    req_point;
    logic [N_REQ-1:0]                 req_sign;

    logic [N_REQ-1:0]                 grant;
    logic                             gnt_chg;
    logic [DATA_W-1:0]                data;
    logic [POINT_W-1:0]               point;
    logic                             en;
    logic                             sign;

    // Requester side: drives requests and their display values, observes the grant
    modport master (
        output dwell_sel, req, req_data, req_point, req_sign,
        input  grant, gnt_chg, data, point, en, sign
    );

    // Arbiter side
    modport slave (
        input  dwell_sel, req, req_data, req_point, req_sign,
        output grant, gnt_chg, data, point, en, sign
    );

endinterface

// File: rtl/rr_pick3.sv
// Round-robin search over three requesters, starting just after the last owner.
module rr_pick3
    import disp_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last_owner,
    output logic [N_REQ-1:0] pick,
    output logic             valid
);

    // Search order rotates so the last owner is considered last
    always_comb begin
        pick  = '0;
        valid = |req;
        case (last_owner)
            2'd0: begin
                if      (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
            end
            2'd1: begin
                if      (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
            end
            default: begin
                if      (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/disp_share_arb.sv
// Time-shares one seven-segment display between three requesters with a round-robin
// dwell-based arbiter and a one-cycle registered display bundle.
module disp_share_arb
    import disp_pkg::*;
#(
    parameter int DWELL_SHORT = DEF_DWELL_SHORT,
    parameter int DWELL_LONG  = DEF_DWELL_LONG
) (
    input  logic              clk,
    input  logic              rst_n,
    disp_share_arb_if.slave   bus
);

    localparam logic [DWELL_W-1:0] SHORT_MAX = DWELL_W'(DWELL_SHORT - 1);
    localparam logic [DWELL_W-1:0] LONG_MAX  = DWELL_W'(DWELL_LONG - 1);

    arb_state_t            state_q, state_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [DWELL_W-1:0]    cnt_q, cnt_d;
    logic [1:0]            last_q, last_d;
    logic                  gnt_chg_q;
    logic [DATA_W-1:0]     data_q;
    logic [POINT_W-1:0]    point_q;
    logic                  en_q;
    logic                  sign_q;

    logic [N_REQ-1:0]      pick;
    logic                  pick_valid;
    logic                  owner_req;
    logic                  expired;
    logic [1:0]            owner_idx;

    rr_pick3 u_pick (
        .req        (bus.req),
        .last_owner (last_q),
        .pick       (pick),
        .valid      (pick_valid)
    );

    assign owner_req = |(bus.req & grant_q);
    assign expired   = cnt_q >= (bus.dwell_sel ? LONG_MAX : SHORT_MAX);
    assign owner_idx = onehot_to_idx(grant_q);

    // Next owner, dwell count and last-owner pointer
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d = OWN;
                    grant_d = pick;
                    last_d  = onehot_to_idx(pick);
                end
            end
            OWN: begin
                if (!owner_req) begin
                    cnt_d = '0;
                    if (pick_valid) begin
                        grant_d = pick;
                        last_d  = onehot_to_idx(pick);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (expired) begin
                    // The owner is searched last, so pick equals the owner only when nobody else waits
                    cnt_d = '0;
                    if (pick != grant_q) begin
                        grant_d = pick;
                        last_d  = onehot_to_idx(pick);
                    end
                end else if (cnt_q < LONG_MAX) begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Arbitration state register with registered grant-change pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            cnt_q     <= '0;
            last_q    <= 2'd2;
            gnt_chg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gnt_chg_q <= (grant_d != grant_q);
        end
    end

    // Display bundle follows the current owner's inputs one cycle later, blanked when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            point_q <= '0;
            en_q    <= 1'b0;
            sign_q  <= 1'b0;
        end else if (grant_q != '0) begin
            data_q  <= bus.req_data[owner_idx];
            point_q <= bus.req_point[owner_idx];
            en_q    <= 1'b1;
            sign_q  <= bus.req_sign[owner_idx];
        end else begin
            data_q  <= '0;
            point_q <= '0;
            en_q    <= 1'b0;
            sign_q  <= 1'b0;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.gnt_chg = gnt_chg_q;
    assign bus.data    = data_q;
    assign bus.point   = point_q;
    assign bus.en      = en_q;
    assign bus.sign    = sign_q;

endmodule

// File: doc/disp_share_arb.md
DISP_SHARE_ARB -- requirements
Module: disp_share_arb

Interface
REQ-001 SHALL have parameter DWELL_SHORT, default 5_000_000, short hold time per owner in clk cycles (100 ms at 50 MHz).
REQ-002 SHALL have parameter DWELL_LONG, default 50_000_000, long hold time per owner in clk cycles (1 s at 50 MHz).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 dwell_sel  input  1  selects hold time: 0 = DWELL_SHORT, 1 = DWELL_LONG.
REQ-006 req  input  3  per-requester display request; bit i belongs to requester i.
REQ-007 req_data  input  3x20  per-requester 6-digit value.
REQ-008 req_point  input  3x6  per-requester decimal-point mask.
REQ-009 req_sign  input  3  per-requester minus-sign flag.
REQ-010 grant  output  3  one-hot current owner; all zeros when idle.
REQ-011 gnt_chg  output  1  one-cycle pulse whenever grant changes value.
REQ-012 data / point / en / sign  output  20 / 6 / 1 / 1  registered bundle to the seven-segment driver.

Function
REQ-013 SHALL have two states: IDLE (grant = 0) and OWN (exactly one grant bit set).
REQ-014 IDLE -> OWN when any req bit is high; the winner is the first requester with req high, searching in round-robin order starting after last_owner.
REQ-015 last_owner SHALL reset to 2, so that requester 0 wins first after reset.
REQ-016 On entering OWN or on any owner change, the dwell counter SHALL clear to 0; in OWN it SHALL increment by 1 each cycle, saturating at DWELL_LONG-1.
REQ-017 Dwell expiry condition: counter >= DWELL-1, where DWELL is chosen by dwell_sel in the current cycle; a mid-dwell change of dwell_sel takes effect immediately.
REQ-018 On expiry with any other req bit high: grant SHALL move to the next requester in round-robin order at that edge, so the owner holds for exactly DWELL cycles.
REQ-019 On expiry with no other requester pending: the owner SHALL be retained, the counter cleared, and gnt_chg SHALL stay 0.
REQ-020 If the owner's req is low in a cycle, grant SHALL pass at that edge to the next pending requester, or to IDLE if none is pending, regardless of the dwell count.
REQ-021 A requester that drops req while not the owner SHALL have no effect; requests are level-sensitive and not latched.
REQ-022 last_owner SHALL update whenever the grant is given to a requester.
REQ-023 Display bundle latency SHALL be 1 cycle: the outputs at cycle t+1 equal the inputs of the owner at cycle t, with en = 1.
REQ-024 When grant = 0 at cycle t, the outputs at t+1 SHALL be data = 0, point = 0, sign = 0, en = 0.
REQ-025 gnt_chg SHALL be registered: high in the first cycle the new grant value is visible, including the transitions into and out of IDLE.
REQ-026 Dwell arithmetic SHALL be 26 bits wide and unsigned.

Reset
REQ-027 While rst_n = 0: state = IDLE, grant = 0, gnt_chg = 0, counter = 0, last_owner = 2, data = 0, point = 0, en = 0, sign = 0.
REQ-028 Reset asserted mid-ownership SHALL clear all state immediately, with no pulse on gnt_chg; after release, arbitration restarts from requester 0.

Structure
REQ-029 A shared package disp_pkg SHALL hold: N_REQ = 3, DATA_W = 20, POINT_W = 6, DWELL_W = 26, and the default dwell constants.
REQ-030 The round-robin search SHALL be a combinational sub-module rr_pick3 (inputs req and last_owner; outputs one-hot pick and valid); it is instantiated once.

Verification (DWELL_SHORT = 4, DWELL_LONG = 10)
REQ-031 Reset, then req = 001 with data0 = 7 -> grant = 001 on the 1st edge, gnt_chg = 1 for 1 cycle, data = 7 with en = 1 on the 2nd edge.
REQ-032 req = 111, dwell_sel = 0 -> grant sequence 001, 010, 100, 001, each held exactly 4 cycles, with gnt_chg pulsed at each change.
REQ-033 Only req0 high for 12 cycles -> grant stays 001 and gnt_chg stays 0 after the first pulse.
REQ-034 Owner 1 drops req at count 2 while req2 is high -> grant = 100 on the next edge; all requests low -> grant = 000 and en = 0 one cycle later.
REQ-035 Owner held 6 cycles with dwell_sel = 1, then dwell_sel switches to 0 while req2 is pending -> handover on the next edge.
REQ-036 rst_n pulsed low while grant = 010 -> all outputs 0 asynchronously; after release with req = 110, grant = 010 (first after last_owner = 2, wrapping to 0 is skipped).
